fifo_rd_packer: RTL and testbench

//   Read-side consumer of the async FIFO: drains the FIFO read port in the rclk

---
 rtl/fifo_rd_packer.sv | 115 +++++++++++
 tb/tb_fifo_rd_packer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Purpose: drains an async-FIFO read port and packs PACK entries into one wide word with a lane-keep mask.
// Latency: m_valid rises 1 cycle after the pop that fills the last lane (or after a flush edge).
// Backpressure: while m_valid & ~m_ready the word is held and popping stops; accumulation resumes the cycle after acceptance.
//
// Ports:
//   rclk, rrst_n          read clock, synchronous active-low reset
//   rdata, rempty, rinc   FIFO read port (rdata valid while rempty=0; rinc is the pop strobe)
//   flush                 level; closes a partial word when at least one lane is filled
//   m_data/m_keep/m_valid/m_ready  packed-word stream, lane 0 = oldest entry
//   words_sent            count of accepted words, wraps
module fifo_rd_packer #(
  parameter int datawidth = 8,
  parameter int PACK      = 4,
  parameter int CNTW      = 16
) (
  input  logic                      rclk,
  input  logic                      rrst_n,
  input  logic [datawidth-1:0]      rdata,
  input  logic                      rempty,
  output logic                      rinc,
  input  logic                      flush,
  output logic [datawidth*PACK-1:0] m_data,
  output logic [PACK-1:0]           m_keep,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CNTW-1:0]           words_sent
);

  localparam int CW = $clog2(PACK + 1);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);
  localparam logic [CW-1:0] LAST_C = CW'(PACK - 1);

  typedef enum logic {ACCUM, OUT} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [datawidth*PACK-1:0] data_q, data_d;
  logic [PACK-1:0]           keep_q, keep_d;
  logic                      valid_q, valid_d;
  logic [CNTW-1:0]           words_q, words_d;

  logic cap;
  logic close_word;

  // Pop only while accumulating with a free lane; reset gates it off immediately.
  assign cap = rrst_n & ~rempty & (state_q == ACCUM) & (cnt_q < PACK_C);
  assign rinc = cap;

  // A word closes when the last lane fills, or on flush if it would carry at least
  // one lane (either already held or captured on this very edge).
  assign close_word = (cap && (cnt_q == LAST_C)) ||
                      (flush && ((cnt_q != '0) || cap));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    words_d = words_q;
    case (state_q)
      ACCUM: begin
        if (cap) begin
          for (int i = 0; i < PACK; i++) begin
            if (cnt_q == CW'(i)) begin
              data_d[i*datawidth +: datawidth] = rdata;
              keep_d[i]                        = 1'b1;
            end
          end
          cnt_d = cnt_q + CW'(1);
        end
        if (close_word) begin
          state_d = OUT;
          valid_d = 1'b1;
        end
      end
      OUT: begin
        // flush is deliberately not latched here; only the handshake leaves OUT.
        if (m_ready) begin
          state_d = ACCUM;
          cnt_d   = '0;
          data_d  = '0;
          keep_d  = '0;
          valid_d = 1'b0;
          words_d = words_q + CNTW'(1);
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      words_q <= words_d;
    end
  end

  assign m_data     = data_q;
  assign m_keep     = keep_q;
  assign m_valid    = valid_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed scenarios followed by a randomized phase,
// all checked every cycle against a queue-based reference of the packing rules.
module tb_fifo_rd_packer;

  localparam int DW   = 8;
  localparam int PACK = 4;
  localparam int CNTW = 4;

  logic              rclk = 1'b0;
  logic              rst_n;
  logic [DW-1:0]     rdata;
  logic              rempty;
  logic              rinc;
  logic              flush;
  logic [DW*PACK-1:0] m_data;
  logic [PACK-1:0]   m_keep;
  logic              m_valid;
  logic              m_ready;
  logic [CNTW-1:0]   words_sent;

  fifo_rd_packer #(.datawidth(DW), .PACK(PACK), .CNTW(CNTW)) dut (
    .rclk      (rclk),
    .rrst_n    (rst_n),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .flush     (flush),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .words_sent(words_sent)
  );

  always #5 rclk = ~rclk;

  // Reference state: FIFO contents, entries popped into the current word,
  // the word waiting for acceptance, and the accepted-word count.
  logic [DW-1:0]      fq[$];
  logic [DW-1:0]      part[$];
  bit                 pend;
  logic [DW*PACK-1:0] pend_data;
  logic [PACK-1:0]    pend_keep;
  int                 exp_words;
  bit                 starve;

  int tests = 0;
  int fails = 0;

  function automatic logic [DW*PACK-1:0] pack_part();
    logic [DW*PACK-1:0] w = '0;
    for (int i = 0; i < part.size(); i++) w = w | ((DW*PACK)'(part[i]) << (DW*i));
    return w;
  endfunction

  function automatic logic [PACK-1:0] keep_part();
    return PACK'((1 << part.size()) - 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present FIFO view, check outputs, advance the reference at the edge.
  task automatic step();
    bit er;
    rempty = starve || (fq.size() == 0);
    rdata  = (fq.size() > 0) ? fq[0] : '0;
    #1;
    er = rst_n && !rempty && !pend;
    chk("rinc",    64'(rinc), 64'(er));
    chk("m_valid", 64'(m_valid), 64'(pend));
    chk("m_data",  64'(m_data), 64'(pend ? pend_data : pack_part()));
    chk("m_keep",  64'(m_keep), 64'(pend ? pend_keep : keep_part()));
    chk("words",   64'(words_sent), 64'(exp_words % (1 << CNTW)));
    @(posedge rclk);
    if (!rst_n) begin
      part.delete();
      pend = 0; pend_data = '0; pend_keep = '0; exp_words = 0;
    end else if (pend) begin
      if (m_ready) begin
        pend = 0;
        exp_words++;
      end
    end else begin
      if (er) part.push_back(fq.pop_front());
      if (part.size() == PACK || (flush && part.size() > 0)) begin
        pend      = 1;
        pend_data = pack_part();
        pend_keep = keep_part();
        part.delete();
      end
    end
    @(negedge rclk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; starve = 0;
    rempty = 1'b1; rdata = '0;
    pend = 0; pend_data = '0; pend_keep = '0; exp_words = 0;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    step();                       // reset state check
    rst_n = 1'b1;

    // 1: four preloaded entries, sink always ready
    m_ready = 1'b1;
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03); fq.push_back(8'h04);
    run(4);
    chk("t1_word", 64'(m_data), 64'h04030201);
    chk("t1_keep", 64'(m_keep), 64'hF);
    run(2);
    chk("t1_words", 64'(words_sent), 64'd1);

    // 2: eight entries with the sink stalled
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
    run(4);
    run(5);
    chk("t2_hold", 64'(m_data), 64'h04030201);
    m_ready = 1'b1;
    run(7);
    chk("t2_words", 64'(words_sent), 64'd3);

    // 3: two entries, FIFO runs dry, single-cycle flush
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    run(4);
    m_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk("t3_word", 64'(m_data), 64'h0000BBAA);
    chk("t3_keep", 64'(m_keep), 64'h3);
    m_ready = 1'b1; run(2);

    // 4: flush on the edge that pops the third entry; then flush with nothing held
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    run(2);
    fq.push_back(8'hCC);
    m_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk("t4_word", 64'(m_data), 64'h00CCBBAA);
    chk("t4_keep", 64'(m_keep), 64'h7);
    m_ready = 1'b1; run(2);
    flush = 1'b1; run(3); flush = 1'b0;
    chk("t4_noword", 64'(m_valid), 64'd0);

    // 5: permanently empty
    run(6);

    // 6: reset after two pops, then a fresh word
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    run(2);
    rst_n = 1'b0; fq.delete(); step(); rst_n = 1'b1;
    chk("t6_keep0", 64'(m_keep), 64'd0);
    for (int i = 0; i < PACK; i++) fq.push_back(DW'(8'h50 + i));
    run(4);
    chk("t6_word", 64'(m_data), 64'h53525150);
    run(2);

    // counter wrap: 2^CNTW more words with the sink always ready
    for (int i = 0; i < (1 << CNTW) * PACK; i++) fq.push_back(DW'($urandom));
    run((1 << CNTW) * (PACK + 1) + 4);
    chk("wrap", 64'(words_sent), 64'(((1 << CNTW) + 1) % (1 << CNTW)));

    // randomized traffic: bursty FIFO, random flush, random backpressure
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 16) fq.push_back(DW'($urandom));
      starve  = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      m_ready = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
